// File: rtl/pc_unit.sv
// pc_unit: program counter with stall, prioritised redirect and a circular return-address stack.
// State updates on the falling edge of CLK; RESET is asynchronous and active-high.
module pc_unit #(
    parameter int                 WIDTH        = 32,
    parameter logic [WIDTH-1:0]   RESET_VECTOR = '0,
    parameter logic [31:0]        EXC_VECTOR   = 32'h0000_0180,
    parameter int                 STEP         = 4,
    parameter int                 RAS_DEPTH    = 4
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             stall,
    input  logic             exc,
    input  logic             ret,
    input  logic             call,
    input  logic             jump,
    input  logic [WIDTH-1:0] jump_target,
    input  logic             branch_taken,
    input  logic [WIDTH-1:0] branch_target,
    output logic [WIDTH-1:0] pc,
    output logic [WIDTH-1:0] pc_plus,
    output logic             ras_empty,
    output logic             ras_full,
    output logic [1:0]       ras_err
);
    localparam int PW = $clog2(RAS_DEPTH);
    localparam int CW = PW + 1;
    localparam logic [WIDTH-1:0] MASK = ~(WIDTH'(STEP - 1));
    localparam logic [WIDTH-1:0] EXC_PC = WIDTH'(EXC_VECTOR);

    logic [WIDTH-1:0] ras [RAS_DEPTH];
    logic [PW-1:0]    top, top_n, push_at;
    logic [CW-1:0]    cnt, cnt_n;
    logic [WIDTH-1:0] pc_n;
    logic [1:0]       err_n;
    logic             push;

    assign pc_plus   = pc + WIDTH'(STEP);
    assign ras_empty = cnt == '0;
    assign ras_full  = cnt == CW'(RAS_DEPTH);

    always_comb begin
        pc_n    = pc_plus;
        top_n   = top;
        cnt_n   = cnt;
        err_n   = ras_err;
        push    = 1'b0;
        push_at = top + 1'b1;
        if (exc) begin
            pc_n = EXC_PC;
        end else if (stall) begin
            pc_n = pc;
        end else if (ret) begin
            if (ras_empty) begin
                pc_n     = jump_target;
                err_n[1] = 1'b1;
                if (call) begin
                    push  = 1'b1;
                    top_n = top + 1'b1;
                    cnt_n = CW'(1);
                end
            end else begin
                pc_n = ras[top];
                // call+ret swaps the top entry in place instead of pop-then-push
                if (call) begin
                    push    = 1'b1;
                    push_at = top;
                end else begin
                    top_n = top - 1'b1;
                    cnt_n = cnt - 1'b1;
                end
            end
        end else if (call) begin
            pc_n  = jump_target;
            push  = 1'b1;
            top_n = top + 1'b1;
            if (ras_full) err_n[0] = 1'b1;
            else cnt_n = cnt + 1'b1;
        end else if (jump) begin
            pc_n = jump_target;
        end else if (branch_taken) begin
            pc_n = branch_target;
        end
    end

    always_ff @(negedge CLK or posedge RESET) begin
        if (RESET) begin
            pc      <= RESET_VECTOR;
            top     <= '0;
            cnt     <= '0;
            ras_err <= '0;
        end else begin
            pc      <= pc_n & MASK;
            top     <= top_n;
            cnt     <= cnt_n;
            ras_err <= err_n;
        end
    end

    // entries are unreadable while empty, so storage needs no reset
    always_ff @(negedge CLK) begin
        if (push) ras[push_at] <= pc_plus;
    end
endmodule
